// File: rtl/dcache_req_arbiter.sv
// Shares one data-cache request port between NrPorts requesters with round-robin
// arbitration, a grant lock held until acceptance, credit limiting and response routing.
module dcache_req_arbiter #(
   parameter int unsigned NrPorts        = 3,
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned TidWidth       = 1,
   parameter int unsigned MaxOutstanding = 7,
   localparam int unsigned PortW         = (NrPorts > 1) ? $clog2(NrPorts) : 1,
   localparam int unsigned BeWidth       = DataWidth / 8,
   localparam int unsigned CacheTidW     = PortW + TidWidth
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [NrPorts-1:0]             req_valid_i,
   output logic [NrPorts-1:0]             req_ready_o,
   input  logic [NrPorts*AddrWidth-1:0]   req_addr_i,
   input  logic [NrPorts-1:0]             req_we_i,
   input  logic [NrPorts*BeWidth-1:0]     req_be_i,
   input  logic [NrPorts*DataWidth-1:0]   req_wdata_i,
   input  logic [NrPorts*TidWidth-1:0]    req_tid_i,
   output logic                           cache_req_valid_o,
   input  logic                           cache_req_ready_i,
   output logic [AddrWidth-1:0]           cache_req_addr_o,
   output logic                           cache_req_we_o,
   output logic [BeWidth-1:0]             cache_req_be_o,
   output logic [DataWidth-1:0]           cache_req_wdata_o,
   output logic [CacheTidW-1:0]           cache_req_tid_o,
   input  logic                           cache_rsp_valid_i,
   input  logic [CacheTidW-1:0]           cache_rsp_tid_i,
   input  logic [DataWidth-1:0]           cache_rsp_rdata_i,
   output logic [NrPorts-1:0]             rsp_valid_o,
   output logic [TidWidth-1:0]            rsp_tid_o,
   output logic [DataWidth-1:0]           rsp_rdata_o,
   output logic [3:0]                     outstanding_o,
   output logic                           idle_o,
   output logic                           err_o
);

   typedef enum logic {IDLE, LOCKED} state_e;

   state_e           state_q, state_d;
   logic [PortW-1:0] rr_ptr_q, rr_ptr_d;
   logic [PortW-1:0] winner_q, winner_d;
   logic [PortW-1:0] rr_idx, rr_sel, sel;
   logic             rr_found;
   logic [3:0]       outstanding_q, outstanding_d;
   logic             err_q, err_d;
   logic             credit, accept;
   logic [PortW-1:0] rsp_idx;
   logic             rsp_idx_ok;

   function automatic logic [PortW-1:0] ptr_inc(input logic [PortW-1:0] p);
      return (32'(p) >= NrPorts - 1) ? '0 : PortW'(32'(p) + 32'd1);
   endfunction

   assign credit = (outstanding_q < 4'(MaxOutstanding));

   // First valid requester at or above rr_ptr, wrapping modulo NrPorts
   always_comb begin
      rr_idx   = '0;
      rr_sel   = '0;
      rr_found = 1'b0;
      for (int unsigned k = 0; k < NrPorts; k++) begin
         rr_idx = PortW'((32'(rr_ptr_q) + k) % NrPorts);
         if (!rr_found && req_valid_i[rr_idx]) begin
            rr_found = 1'b1;
            rr_sel   = rr_idx;
         end
      end
   end

   always_comb begin
      state_d           = state_q;
      rr_ptr_d          = rr_ptr_q;
      winner_d          = winner_q;
      sel               = rr_sel;
      cache_req_valid_o = 1'b0;
      req_ready_o       = '0;
      case (state_q)
         IDLE: begin
            sel               = rr_sel;
            cache_req_valid_o = rr_found & credit & rst_ni;
            if (cache_req_valid_o) begin
               if (cache_req_ready_i) begin
                  req_ready_o[sel] = 1'b1;
                  rr_ptr_d         = ptr_inc(sel);
               end else begin
                  winner_d = sel;
                  state_d  = LOCKED;
               end
            end
         end
         LOCKED: begin
            // Credit cannot drop here: only responses change the count while locked
            sel               = winner_q;
            cache_req_valid_o = req_valid_i[winner_q] & rst_ni;
            if (!req_valid_i[winner_q]) begin
               state_d = IDLE;
            end else if (cache_req_ready_i) begin
               req_ready_o[winner_q] = 1'b1;
               rr_ptr_d              = ptr_inc(winner_q);
               state_d               = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept = cache_req_valid_o & cache_req_ready_i;

   // Payload of the selected requester, zero while no request is presented
   always_comb begin
      cache_req_addr_o  = '0;
      cache_req_we_o    = 1'b0;
      cache_req_be_o    = '0;
      cache_req_wdata_o = '0;
      cache_req_tid_o   = '0;
      if (cache_req_valid_o) begin
         for (int unsigned i = 0; i < NrPorts; i++) begin
            if (sel == PortW'(i)) begin
               cache_req_addr_o  = req_addr_i[i*AddrWidth +: AddrWidth];
               cache_req_we_o    = req_we_i[i];
               cache_req_be_o    = req_be_i[i*BeWidth +: BeWidth];
               cache_req_wdata_o = req_wdata_i[i*DataWidth +: DataWidth];
               cache_req_tid_o   = {sel, req_tid_i[i*TidWidth +: TidWidth]};
            end
         end
      end
   end

   assign rsp_idx    = cache_rsp_tid_i[TidWidth +: PortW];
   assign rsp_idx_ok = (32'(rsp_idx) < NrPorts);

   always_comb begin
      rsp_valid_o = '0;
      for (int unsigned i = 0; i < NrPorts; i++) begin
         rsp_valid_o[i] = cache_rsp_valid_i & rst_ni & (rsp_idx == PortW'(i));
      end
   end

   assign rsp_tid_o   = cache_rsp_tid_i[TidWidth-1:0];
   assign rsp_rdata_o = cache_rsp_rdata_i;

   // In-flight count saturating at zero; unroutable or unexpected responses are sticky errors
   always_comb begin
      outstanding_d = outstanding_q;
      err_d         = err_q;
      if (cache_rsp_valid_i && (!rsp_idx_ok || outstanding_q == 4'd0)) begin
         err_d = 1'b1;
      end
      if (accept && !cache_rsp_valid_i) begin
         outstanding_d = outstanding_q + 4'd1;
      end else if (!accept && cache_rsp_valid_i && outstanding_q != 4'd0) begin
         outstanding_d = outstanding_q - 4'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         rr_ptr_q      <= '0;
         winner_q      <= '0;
         outstanding_q <= '0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         winner_q      <= winner_d;
         outstanding_q <= outstanding_d;
         err_q         <= err_d;
      end
   end

   assign outstanding_o = outstanding_q;
   assign idle_o        = (outstanding_q == 4'd0) && (state_q == IDLE);
   assign err_o         = err_q;

`ifndef SYNTHESIS
   locked_valid_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (state_q == LOCKED) |-> req_valid_i[winner_q]);
`endif

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Directed bench for dcache_req_arbiter: vector table plus credit and reset-while-locked sequences.
module tb_dcache_req_arbiter;

   logic        clk_i;
   logic        rst_ni;
   logic [2:0]  req_valid_i;
   logic [2:0]  req_ready_o;
   logic [95:0] req_addr_i;
   logic [2:0]  req_we_i;
   logic [11:0] req_be_i;
   logic [95:0] req_wdata_i;
   logic [2:0]  req_tid_i;
   logic        cache_req_valid_o;
   logic        cache_req_ready_i;
   logic [31:0] cache_req_addr_o;
   logic        cache_req_we_o;
   logic [3:0]  cache_req_be_o;
   logic [31:0] cache_req_wdata_o;
   logic [2:0]  cache_req_tid_o;
   logic        cache_rsp_valid_i;
   logic [2:0]  cache_rsp_tid_i;
   logic [31:0] cache_rsp_rdata_i;
   logic [2:0]  rsp_valid_o;
   logic [0:0]  rsp_tid_o;
   logic [31:0] rsp_rdata_o;
   logic [3:0]  outstanding_o;
   logic        idle_o;
   logic        err_o;

   dcache_req_arbiter dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_addr_i(req_addr_i), .req_we_i(req_we_i), .req_be_i(req_be_i),
      .req_wdata_i(req_wdata_i), .req_tid_i(req_tid_i),
      .cache_req_valid_o(cache_req_valid_o), .cache_req_ready_i(cache_req_ready_i),
      .cache_req_addr_o(cache_req_addr_o), .cache_req_we_o(cache_req_we_o),
      .cache_req_be_o(cache_req_be_o), .cache_req_wdata_o(cache_req_wdata_o),
      .cache_req_tid_o(cache_req_tid_o),
      .cache_rsp_valid_i(cache_rsp_valid_i), .cache_rsp_tid_i(cache_rsp_tid_i),
      .cache_rsp_rdata_i(cache_rsp_rdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_tid_o(rsp_tid_o), .rsp_rdata_o(rsp_rdata_o),
      .outstanding_o(outstanding_o), .idle_o(idle_o), .err_o(err_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [2:0] v;
      logic       rdy;
      logic       rv;
      logic [2:0] rtid;
      logic       ecv;
      logic [1:0] eport;
      logic [2:0] erdy;
      logic [3:0] eout;
      logic [2:0] ersp;
      logic       eerr;
      logic       eidle;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs [NV];

   int checks   = 0;
   int failures = 0;

   function automatic logic [31:0] addr_of(input int p);
      return 32'hA000_0004 + 32'(p) * 32'h100;
   endfunction
   function automatic logic [3:0] be_of(input int p);
      return 4'(1 << p);
   endfunction
   function automatic logic [31:0] wdata_of(input int p);
      return 32'h5500_0000 + 32'(p);
   endfunction
   function automatic logic tid_of(input int p);
      return 1'(p & 1);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] v, input logic rdy, input logic rv, input logic [2:0] rtid);
      req_valid_i       = v;
      cache_req_ready_i = rdy;
      cache_rsp_valid_i = rv;
      cache_rsp_tid_i   = rtid;
   endtask

   initial begin
      int acc;
      int p;
      //          v       rdy   rv    rtid    ecv  eport erdy    eout  ersp    eerr  eidle
      vecs[0]  = '{3'b111, 1'b1, 1'b0, 3'b000, 1'b1, 2'd0, 3'b001, 4'd0, 3'b000, 1'b0, 1'b1};
      vecs[1]  = '{3'b111, 1'b1, 1'b0, 3'b000, 1'b1, 2'd1, 3'b010, 4'd1, 3'b000, 1'b0, 1'b0};
      vecs[2]  = '{3'b111, 1'b1, 1'b1, 3'b000, 1'b1, 2'd2, 3'b100, 4'd2, 3'b001, 1'b0, 1'b0};
      vecs[3]  = '{3'b111, 1'b1, 1'b1, 3'b011, 1'b1, 2'd0, 3'b001, 4'd2, 3'b010, 1'b0, 1'b0};
      vecs[4]  = '{3'b111, 1'b1, 1'b1, 3'b100, 1'b1, 2'd1, 3'b010, 4'd2, 3'b100, 1'b0, 1'b0};
      vecs[5]  = '{3'b111, 1'b1, 1'b1, 3'b000, 1'b1, 2'd2, 3'b100, 4'd2, 3'b001, 1'b0, 1'b0};
      vecs[6]  = '{3'b000, 1'b1, 1'b1, 3'b011, 1'b0, 2'd0, 3'b000, 4'd2, 3'b010, 1'b0, 1'b0};
      vecs[7]  = '{3'b000, 1'b0, 1'b1, 3'b100, 1'b0, 2'd0, 3'b000, 4'd1, 3'b100, 1'b0, 1'b0};
      vecs[8]  = '{3'b010, 1'b0, 1'b0, 3'b000, 1'b1, 2'd1, 3'b000, 4'd0, 3'b000, 1'b0, 1'b1};
      vecs[9]  = '{3'b011, 1'b0, 1'b0, 3'b000, 1'b1, 2'd1, 3'b000, 4'd0, 3'b000, 1'b0, 1'b0};
      vecs[10] = '{3'b011, 1'b0, 1'b0, 3'b000, 1'b1, 2'd1, 3'b000, 4'd0, 3'b000, 1'b0, 1'b0};
      vecs[11] = '{3'b011, 1'b1, 1'b0, 3'b000, 1'b1, 2'd1, 3'b010, 4'd0, 3'b000, 1'b0, 1'b0};
      vecs[12] = '{3'b001, 1'b1, 1'b0, 3'b000, 1'b1, 2'd0, 3'b001, 4'd1, 3'b000, 1'b0, 1'b0};
      vecs[13] = '{3'b001, 1'b1, 1'b0, 3'b000, 1'b1, 2'd0, 3'b001, 4'd2, 3'b000, 1'b0, 1'b0};
      vecs[14] = '{3'b100, 1'b1, 1'b1, 3'b000, 1'b1, 2'd2, 3'b100, 4'd3, 3'b001, 1'b0, 1'b0};
      vecs[15] = '{3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 3'b000, 4'd3, 3'b000, 1'b0, 1'b0};
      vecs[16] = '{3'b000, 1'b0, 1'b1, 3'b111, 1'b0, 2'd0, 3'b000, 4'd3, 3'b000, 1'b0, 1'b0};
      vecs[17] = '{3'b000, 1'b0, 1'b1, 3'b101, 1'b0, 2'd0, 3'b000, 4'd2, 3'b100, 1'b1, 1'b0};
      vecs[18] = '{3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 3'b000, 4'd1, 3'b000, 1'b1, 1'b0};
      vecs[19] = '{3'b000, 1'b0, 1'b1, 3'b001, 1'b0, 2'd0, 3'b000, 4'd1, 3'b001, 1'b1, 1'b0};
      vecs[20] = '{3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 3'b000, 4'd0, 3'b000, 1'b1, 1'b1};

      rst_ni = 1'b0;
      drive(3'b000, 1'b0, 1'b0, 3'b000);
      cache_rsp_rdata_i = '0;
      for (int i = 0; i < 3; i++) begin
         req_addr_i[i*32 +: 32]  = addr_of(i);
         req_we_i[i]             = (i == 1);
         req_be_i[i*4 +: 4]      = be_of(i);
         req_wdata_i[i*32 +: 32] = wdata_of(i);
         req_tid_i[i]            = tid_of(i);
      end

      repeat (2) @(negedge clk_i);
      #1;
      check("reset outstanding", 32'(outstanding_o), 32'd0);
      check("reset cache_valid", 32'(cache_req_valid_o), 32'd0);
      check("reset err", 32'(err_o), 32'd0);
      check("reset idle", 32'(idle_o), 32'd1);
      rst_ni = 1'b1;

      for (int r = 0; r < NV; r++) begin
         @(negedge clk_i);
         drive(vecs[r].v, vecs[r].rdy, vecs[r].rv, vecs[r].rtid);
         cache_rsp_rdata_i = 32'hD000_0000 + 32'(r);
         #1;
         p = int'(vecs[r].eport);
         check($sformatf("row%0d cache_valid", r), 32'(cache_req_valid_o), 32'(vecs[r].ecv));
         check($sformatf("row%0d req_ready", r), 32'(req_ready_o), 32'(vecs[r].erdy));
         check($sformatf("row%0d outstanding", r), 32'(outstanding_o), 32'(vecs[r].eout));
         check($sformatf("row%0d rsp_valid", r), 32'(rsp_valid_o), 32'(vecs[r].ersp));
         check($sformatf("row%0d err", r), 32'(err_o), 32'(vecs[r].eerr));
         check($sformatf("row%0d idle", r), 32'(idle_o), 32'(vecs[r].eidle));
         if (vecs[r].ecv) begin
            check($sformatf("row%0d tid", r), 32'(cache_req_tid_o), 32'({vecs[r].eport, tid_of(p)}));
            check($sformatf("row%0d addr", r), cache_req_addr_o, addr_of(p));
            check($sformatf("row%0d we", r), 32'(cache_req_we_o), 32'(p == 1));
            check($sformatf("row%0d be", r), 32'(cache_req_be_o), 32'(be_of(p)));
            check($sformatf("row%0d wdata", r), cache_req_wdata_o, wdata_of(p));
         end else begin
            check($sformatf("row%0d idle addr", r), cache_req_addr_o, 32'd0);
            check($sformatf("row%0d idle tid", r), 32'(cache_req_tid_o), 32'd0);
         end
         if (vecs[r].rv) begin
            check($sformatf("row%0d rsp_tid", r), 32'(rsp_tid_o), 32'(vecs[r].rtid[0]));
            check($sformatf("row%0d rsp_rdata", r), rsp_rdata_o, 32'hD000_0000 + 32'(r));
         end
      end

      // Credit exhaustion: port 2 only, no responses
      acc = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk_i);
         drive(3'b100, 1'b1, 1'b0, 3'b000);
         #1;
         acc += int'(req_ready_o[2]);
         check($sformatf("credit%0d cache_valid", k), 32'(cache_req_valid_o), 32'(k < 7));
         check($sformatf("credit%0d outstanding", k), 32'(outstanding_o), 32'((k < 7) ? k : 7));
      end
      @(negedge clk_i);
      drive(3'b100, 1'b1, 1'b1, 3'b100);
      #1;
      check("credit accepted", 32'(acc), 32'd7);
      check("credit full count", 32'(outstanding_o), 32'd7);
      check("credit no bypass", 32'(cache_req_valid_o), 32'd0);
      check("credit rsp strobe", 32'(rsp_valid_o), 32'b100);
      @(negedge clk_i);
      drive(3'b100, 1'b1, 1'b0, 3'b000);
      #1;
      check("credit freed valid", 32'(cache_req_valid_o), 32'd1);
      check("credit freed ready", 32'(req_ready_o), 32'b100);
      check("credit freed count", 32'(outstanding_o), 32'd6);
      @(negedge clk_i);
      drive(3'b000, 1'b0, 1'b0, 3'b000);
      #1;
      check("credit refill count", 32'(outstanding_o), 32'd7);

      // Reset while locked with five in flight
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         drive(3'b000, 1'b0, 1'b1, 3'b100);
      end
      @(negedge clk_i);
      drive(3'b001, 1'b1, 1'b0, 3'b000);
      #1;
      check("prelock ready", 32'(req_ready_o), 32'b001);
      check("prelock count", 32'(outstanding_o), 32'd4);
      @(negedge clk_i);
      drive(3'b010, 1'b0, 1'b0, 3'b000);
      #1;
      check("lock tid", 32'(cache_req_tid_o), 32'b011);
      @(negedge clk_i);
      #1;
      check("locked count", 32'(outstanding_o), 32'd5);
      check("locked idle", 32'(idle_o), 32'd0);
      check("locked err", 32'(err_o), 32'd1);
      rst_ni = 1'b0;
      drive(3'b111, 1'b1, 1'b1, 3'b000);
      #1;
      check("async rst count", 32'(outstanding_o), 32'd0);
      check("async rst cache_valid", 32'(cache_req_valid_o), 32'd0);
      check("async rst rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("async rst req_ready", 32'(req_ready_o), 32'd0);
      check("async rst err", 32'(err_o), 32'd0);
      check("async rst idle", 32'(idle_o), 32'd1);
      @(negedge clk_i);
      rst_ni = 1'b1;
      drive(3'b111, 1'b1, 1'b0, 3'b000);
      #1;
      check("post rst valid", 32'(cache_req_valid_o), 32'd1);
      check("post rst tid", 32'(cache_req_tid_o), 32'b000);
      check("post rst ready", 32'(req_ready_o), 32'b001);
      @(negedge clk_i);
      drive(3'b000, 1'b0, 1'b0, 3'b000);
      #1;
      check("post rst count", 32'(outstanding_o), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
